// File: rtl/mem_stage.sv
// MIPS MEM stage: word data memory with configurable wait states, branch resolve,
// upstream stall generation and the MEM/WB pipeline register.
module mem_stage #(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_ctl,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2out,
  input  logic [4:0]  five_bit_muxout,
  input  logic [31:0] EX_MEM_NPC,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic [1:0]  mem_wb_ctl,
  output logic [31:0] mem_wb_rdata,
  output logic [31:0] mem_wb_alu,
  output logic [4:0]  mem_wb_wreg
);
  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             st, st_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               req, stall_i, done;
  logic [ADDR_W-1:0]  addr;
  logic [31:0]        mem [DEPTH_WORDS];
  logic [31:0]        ld_data;

  assign req           = memread | memwrite;
  assign addr          = alu_result[ADDR_W+1:2];
  assign pcsrc         = branch & zero;
  assign branch_target = EX_MEM_NPC;
  assign stall         = stall_i & ~rst;

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    stall_i = 1'b0;
    done    = 1'b0;
    case (st)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            done = 1'b1;
          end else begin
            st_nxt  = S_WAIT;
            cnt_nxt = CNT_W'(WAIT_STATES - 1);
            stall_i = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
          stall_i = 1'b1;
        end else begin
          done   = 1'b1;
          st_nxt = S_IDLE;
        end
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  // store wins over a simultaneous load, so only a pure load returns data
  assign ld_data = (done && memread && !memwrite) ? mem[addr] : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= S_IDLE;
      cnt          <= '0;
      mem_wb_ctl   <= '0;
      mem_wb_rdata <= '0;
      mem_wb_alu   <= '0;
      mem_wb_wreg  <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
      if (stall_i) begin
        mem_wb_ctl   <= '0;
        mem_wb_rdata <= '0;
        mem_wb_alu   <= '0;
        mem_wb_wreg  <= '0;
      end else begin
        mem_wb_ctl   <= wb_ctl;
        mem_wb_rdata <= ld_data;
        mem_wb_alu   <= alu_result;
        mem_wb_wreg  <= five_bit_muxout;
      end
    end
  end

  // contents are deliberately not reset; reset aborts an in-flight store
  always_ff @(posedge clk) begin
    if (!rst && done && memwrite) mem[addr] <= rdata2out;
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench: WAIT_STATES=2 instance for multi-cycle sequences, WAIT_STATES=0
// instance driven from a vector table.
module tb_mem_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- instance A: WAIT_STATES = 2 ----------------
  localparam int WS = 2;
  logic        a_rst, a_branch, a_memread, a_memwrite, a_zero;
  logic [1:0]  a_wb_ctl;
  logic [31:0] a_alu, a_wdata, a_npc;
  logic [4:0]  a_wreg;
  logic        a_pcsrc, a_stall;
  logic [31:0] a_btgt, a_rdata, a_walu;
  logic [1:0]  a_ctl;
  logic [4:0]  a_owreg;

  mem_stage #(.WAIT_STATES(WS), .DEPTH_WORDS(256)) u_a (
    .clk(clk), .rst(a_rst), .wb_ctl(a_wb_ctl), .branch(a_branch),
    .memread(a_memread), .memwrite(a_memwrite), .zero(a_zero),
    .alu_result(a_alu), .rdata2out(a_wdata), .five_bit_muxout(a_wreg),
    .EX_MEM_NPC(a_npc), .pcsrc(a_pcsrc), .branch_target(a_btgt),
    .stall(a_stall), .mem_wb_ctl(a_ctl), .mem_wb_rdata(a_rdata),
    .mem_wb_alu(a_walu), .mem_wb_wreg(a_owreg)
  );

  // ---------------- instance B: WAIT_STATES = 0 ----------------
  logic        b_rst, b_memread, b_memwrite;
  logic [1:0]  b_wb_ctl;
  logic [31:0] b_alu, b_wdata;
  logic [4:0]  b_wreg;
  logic        b_pcsrc, b_stall;
  logic [31:0] b_btgt, b_rdata, b_walu;
  logic [1:0]  b_ctl;
  logic [4:0]  b_owreg;

  mem_stage #(.WAIT_STATES(0), .DEPTH_WORDS(256)) u_b (
    .clk(clk), .rst(b_rst), .wb_ctl(b_wb_ctl), .branch(1'b0),
    .memread(b_memread), .memwrite(b_memwrite), .zero(1'b0),
    .alu_result(b_alu), .rdata2out(b_wdata), .five_bit_muxout(b_wreg),
    .EX_MEM_NPC(32'h0), .pcsrc(b_pcsrc), .branch_target(b_btgt),
    .stall(b_stall), .mem_wb_ctl(b_ctl), .mem_wb_rdata(b_rdata),
    .mem_wb_alu(b_walu), .mem_wb_wreg(b_owreg)
  );

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [1:0]  ctl;
    logic [4:0]  wreg;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[9];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic a_idle();
    a_memread = 0; a_memwrite = 0; a_wb_ctl = 0; a_wreg = 0;
    a_alu = 0; a_wdata = 0; a_branch = 0; a_zero = 0; a_npc = 0;
  endtask

  // full WS+1 cycle access on A with stall/bubble checks along the way
  task automatic a_access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] ctl,
                          input logic [4:0] wreg, input logic [31:0] exp_rdata);
    a_memread = rd; a_memwrite = wr; a_alu = addr; a_wdata = wdata;
    a_wb_ctl = ctl; a_wreg = wreg;
    for (int c = 0; c <= WS; c++) begin
      #3; chk($sformatf("a_stall_c%0d", c), {31'h0, a_stall}, {31'h0, c < WS});
      tick();
      if (c < WS) chk($sformatf("a_bubble_ctl_c%0d", c), {30'h0, a_ctl}, 32'h0);
    end
    chk("a_wb_rdata", a_rdata, exp_rdata);
    chk("a_wb_ctl", {30'h0, a_ctl}, {30'h0, ctl});
    chk("a_wb_wreg", {27'h0, a_owreg}, {27'h0, wreg});
    chk("a_wb_alu", a_walu, addr);
    a_idle();
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h000, 32'hA0A0A0A0, 2'b01, 5'd1, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h000, 32'h0,        2'b11, 5'd2, 32'hA0A0A0A0};
    vecs[2] = '{1'b0, 1'b1, 32'h004, 32'h00001234, 2'b00, 5'd3, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h004, 32'h0,        2'b10, 5'd4, 32'h00001234};
    vecs[4] = '{1'b1, 1'b1, 32'h008, 32'hCAFEF00D, 2'b11, 5'd5, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h008, 32'h0,        2'b01, 5'd6, 32'hCAFEF00D};
    vecs[6] = '{1'b0, 1'b0, 32'h077, 32'h0,        2'b10, 5'd7, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 32'h3FC, 32'hFFFF0000, 2'b01, 5'd8, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 32'h3FD, 32'h0,        2'b11, 5'd9, 32'hFFFF0000};

    a_idle(); a_rst = 1;
    b_rst = 1; b_memread = 0; b_memwrite = 0; b_wb_ctl = 0; b_alu = 0; b_wdata = 0; b_wreg = 0;
    tick(); tick();
    a_rst = 0; b_rst = 0;
    chk("rst_a_ctl", {30'h0, a_ctl}, 32'h0);
    chk("rst_a_rdata", a_rdata, 32'h0);
    chk("rst_a_alu", a_walu, 32'h0);
    chk("rst_a_wreg", {27'h0, a_owreg}, 32'h0);
    chk("rst_a_stall", {31'h0, a_stall}, 32'h0);

    // reset with memwrite held must not touch memory
    a_access(0, 1, 32'h30, 32'h11111111, 2'b01, 5'd1, 32'h0);
    a_rst = 1; a_memwrite = 1; a_alu = 32'h30; a_wdata = 32'hBADBAD00; a_wb_ctl = 2'b11; a_wreg = 5'd3;
    #3; chk("rst_stall_forced", {31'h0, a_stall}, 32'h0);
    tick(); tick();
    chk("rst_hold_ctl", {30'h0, a_ctl}, 32'h0);
    chk("rst_hold_alu", a_walu, 32'h0);
    a_rst = 0; a_idle(); tick();
    a_access(1, 0, 32'h30, 32'h0, 2'b11, 5'd2, 32'h11111111);

    // store then load
    a_access(0, 1, 32'h10, 32'hDEADBEEF, 2'b00, 5'd0, 32'h0);
    a_access(1, 0, 32'h10, 32'h0, 2'b11, 5'd5, 32'hDEADBEEF);

    // wrap and ignored low bits: 0x403 -> word 0
    a_access(0, 1, 32'h403, 32'h12345678, 2'b00, 5'd0, 32'h0);
    a_access(1, 0, 32'h000, 32'h0, 2'b10, 5'd9, 32'h12345678);

    // branch resolution is combinational
    a_branch = 1; a_zero = 1; a_npc = 32'h40;
    #1; chk("pcsrc_taken", {31'h0, a_pcsrc}, 32'h1);
    chk("branch_target", a_btgt, 32'h40);
    a_zero = 0;
    #1; chk("pcsrc_not_taken", {31'h0, a_pcsrc}, 32'h0);
    a_branch = 0; a_zero = 1;
    #1; chk("pcsrc_no_branch", {31'h0, a_pcsrc}, 32'h0);
    a_idle(); tick();

    // reset during second stall cycle aborts the store
    a_access(0, 1, 32'h20, 32'h0BADF00D, 2'b00, 5'd0, 32'h0);
    a_memwrite = 1; a_alu = 32'h20; a_wdata = 32'hAAAA5555; a_wb_ctl = 2'b11; a_wreg = 5'd4;
    #3; chk("abort_stall0", {31'h0, a_stall}, 32'h1);
    tick();
    chk("abort_bubble", {30'h0, a_ctl}, 32'h0);
    a_rst = 1;
    #1; chk("abort_stall_rst", {31'h0, a_stall}, 32'h0);
    tick();
    a_rst = 0; a_idle();
    chk("abort_wb_alu", a_walu, 32'h0);
    tick();
    a_access(1, 0, 32'h20, 32'h0, 2'b01, 5'd6, 32'h0BADF00D);

    // non-memory op flows straight through
    a_wb_ctl = 2'b10; a_alu = 32'h55; a_wreg = 5'd7;
    #3; chk("alu_op_stall", {31'h0, a_stall}, 32'h0);
    tick();
    chk("alu_op_wb_alu", a_walu, 32'h55);
    chk("alu_op_wb_wreg", {27'h0, a_owreg}, 32'd7);
    a_idle();

    // WAIT_STATES=0 instance: one access per cycle
    for (int i = 0; i < 9; i++) begin
      b_memread = vecs[i].rd; b_memwrite = vecs[i].wr; b_alu = vecs[i].addr;
      b_wdata = vecs[i].wdata; b_wb_ctl = vecs[i].ctl; b_wreg = vecs[i].wreg;
      #3; chk($sformatf("b_stall_%0d", i), {31'h0, b_stall}, 32'h0);
      tick();
      chk($sformatf("b_rdata_%0d", i), b_rdata, vecs[i].exp_rdata);
      chk($sformatf("b_ctl_%0d", i), {30'h0, b_ctl}, {30'h0, vecs[i].ctl});
      chk($sformatf("b_alu_%0d", i), b_walu, vecs[i].addr);
      chk($sformatf("b_wreg_%0d", i), {27'h0, b_owreg}, {27'h0, vecs[i].wreg});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory (MEM) stage of the five-stage MIPS pipeline: consumes the EX/MEM latch outputs produced by the execute stage, performs word loads and stores against an internal data memory with configurable wait states, resolves branch taken/not-taken, and drives the MEM/WB pipeline register. When an access needs wait states, the block stalls upstream and inserts bubbles into MEM/WB.

## Interface
- WAIT_STATES, 2: extra cycles per load/store beyond the first; 0 means a single-cycle access with no stall.
- DEPTH_WORDS, 256: data memory depth in 32-bit words; power of two. ADDR_W = log2(DEPTH_WORDS).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- wb_ctl  in  2  write-back control from EX/MEM
- branch  in  1  branch instruction flag
- memread  in  1  load request
- memwrite  in  1  store request
- zero  in  1  ALU zero flag
- alu_result  in  32  effective address, or ALU value for write-back
- rdata2out  in  32  store data
- five_bit_muxout  in  5  destination register number
- EX_MEM_NPC  in  32  branch target address
- pcsrc  out  1  branch taken, equal to branch & zero
- branch_target  out  32  EX_MEM_NPC passed through
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM stable
- mem_wb_ctl  out  2  registered write-back control
- mem_wb_rdata  out  32  registered load data
- mem_wb_alu  out  32  registered alu_result
- mem_wb_wreg  out  5  registered destination register

## Operation
- Word address is alu_result[ADDR_W+1:2]. Bits [1:0] are ignored; no alignment fault. Upper bits are ignored, so out-of-range addresses wrap.
- The access request is req = memread | memwrite. If both are asserted, the access is a store and mem_wb_rdata = 0.
- Data memory contents are not reset; the initial contents are undefined.
- FSM states: IDLE and WAIT, with a wait counter cnt of width clog2(WAIT_STATES+1).
  - IDLE with req and WAIT_STATES>0: go to WAIT, set cnt = WAIT_STATES-1, assert stall.
  - WAIT with cnt>0: decrement cnt, keep stall asserted.
  - WAIT with cnt==0: deassert stall. Perform the access at this clock edge (store commits, load data is captured). Return to IDLE.
  - IDLE with req and WAIT_STATES==0: the access completes at the same edge with no stall.
  - IDLE without req: no memory access.
- stall = (IDLE & req & WAIT_STATES>0) | (WAIT & cnt>0).
- The stall output is combinational and forced to 0 while rst is high.
- MEM/WB load rule:
  - Each edge with stall=0: load wb_ctl, the load data (or 0 for non-loads), alu_result and five_bit_muxout.
  - Each edge with stall=1: load a bubble, i.e. all MEM/WB outputs = 0.
- pcsrc and branch_target are combinational from the inputs and are unaffected by stall.
- Upstream must hold every input stable while stall=1. Behaviour when inputs change during a stall is undefined.

## Timing
- Reset values: FSM = IDLE, cnt = 0, mem_wb_* = 0, stall = 0.
- Reset asserted mid-access: the access is aborted, the store is not committed, and the FSM returns to IDLE on that edge.
- Load/store latency: WAIT_STATES+1 cycles from the first cycle req is seen. stall is high for the first WAIT_STATES of those cycles.
- Load data appears on mem_wb_rdata the cycle after the completing edge.
- A store is readable by a load that starts in the following cycle.
- Back-to-back accesses: each access independently pays its full WAIT_STATES; there is no pipelining of memory accesses.
- A non-memory instruction following a memory access flows through in 1 cycle.

## Test plan
- Reset: assert rst for 2 cycles while memwrite=1 -> all mem_wb_* = 0, stall = 0, and the memory at that address is unchanged.
- Store then load (WAIT_STATES=2):
  - Store: alu_result=0x10, rdata2out=0xDEADBEEF, memwrite=1 -> stall high for 2 cycles, then low.
  - Load: same address, memread=1, wb_ctl=2'b11, five_bit_muxout=5 -> after 3 cycles mem_wb_rdata=0xDEADBEEF, mem_wb_wreg=5, mem_wb_ctl=2'b11.
  - mem_wb_ctl = 0 during both stall cycles.
- Address wrap and low bits: store 0x12345678 at alu_result=0x403, then load from 0x000 (DEPTH_WORDS=256) -> returns 0x12345678.
- Branch: branch=1, zero=1, EX_MEM_NPC=0x40 -> pcsrc=1, branch_target=0x40 in the same cycle. With zero=0 -> pcsrc=0.
- Reset mid-access: store 0xAAAA5555 to 0x20 with rst pulsed during the second stall cycle -> a subsequent load from 0x20 returns the prior value, and the FSM restarts from IDLE.
- WAIT_STATES=0 build: alternate loads and stores every cycle -> stall never asserts, and load data appears one cycle later.
